// File: rtl/led_scan_pkg.sv
// Shared types and width rules for the LED frame scanner.
//   scan_state_t : scanner FSM states (idle, blanking gap, lit column)
//   x_width      : column index width; the LED array driver uses the same rule
//   timer_width  : width of the dwell/blank down-counter
package led_scan_pkg;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} scan_state_t;

  // One spare bit over $clog2(n) so that n=1 still yields a 1-bit index.
  function automatic int x_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Wide enough to hold the larger of the two phase lengths.
  function automatic int timer_width(input int dwell, input int blank);
    return $clog2(((dwell > blank) ? dwell : blank) + 1);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter with a zero flag, shared by the blank and lit phases.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load load_val this cycle (takes priority over dec)
//   dec      : decrement by one this cycle
//   load_val : value to load
//   zero     : count is zero (decoded from the count register)
module scan_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/led_frame_scanner.sv
// Column scanner for the LED array driver. Lights one column of the NxN grid at a
// time (BLANK_CYCLES dark, then DWELL_CYCLES lit), and double-buffers incoming
// generations so a new board is only shown from a frame boundary.
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset
//   run         : 1 = keep scanning; 0 = stop after the current column
//   cells_in    : next generation, bit b*N+a
//   cells_valid : cells_in valid
//   cells_ready : pending buffer empty, a transfer will be accepted
//   ena         : column enable to the driver
//   x           : active column index 0..N-1
//   cells_out   : generation currently displayed
//   frame_done  : one-cycle pulse after column N-1 finishes
module led_frame_scanner
  import led_scan_pkg::*;
#(
  parameter int N            = 5,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [N*N-1:0]         cells_in,
  input  logic                   cells_valid,
  output logic                   cells_ready,
  output logic                   ena,
  output logic [x_width(N)-1:0]  x,
  output logic [N*N-1:0]         cells_out,
  output logic                   frame_done
);

  localparam int X_W = x_width(N);
  localparam int T_W = timer_width(DWELL_CYCLES, BLANK_CYCLES);

  scan_state_t    state_reg, state_next;
  logic [X_W-1:0] x_reg, x_next;
  logic           ena_reg;
  logic           frame_done_reg;
  logic [N*N-1:0] cells_out_reg;
  logic [N*N-1:0] pending_reg;
  logic           pending_full_reg, pending_full_next;
  logic           cells_ready_reg;

  logic           timer_load, timer_dec, timer_zero;
  logic [T_W-1:0] timer_load_val;
  logic           col_end, last_col, frame_end;
  logic           accept, swap;

  scan_timer #(.W(T_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .dec      (timer_dec),
    .load_val (timer_load_val),
    .zero     (timer_zero)
  );

  assign last_col  = (x_reg == X_W'(N - 1));
  assign frame_end = col_end && last_col;

  // Next state and timer control. run is only looked at in IDLE and at the end
  // of a lit column, so a column that has started is always shown in full.
  always_comb begin
    state_next     = state_reg;
    timer_load     = 1'b0;
    timer_dec      = 1'b0;
    timer_load_val = '0;
    col_end        = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (run) begin
          state_next     = S_BLANK;
          timer_load     = 1'b1;
          timer_load_val = T_W'(BLANK_CYCLES - 1);
        end
      end
      S_BLANK: begin
        if (timer_zero) begin
          state_next     = S_SHOW;
          timer_load     = 1'b1;
          timer_load_val = T_W'(DWELL_CYCLES - 1);
        end else begin
          timer_dec = 1'b1;
        end
      end
      S_SHOW: begin
        if (timer_zero) begin
          col_end = 1'b1;
          if (run) begin
            state_next     = S_BLANK;
            timer_load     = 1'b1;
            timer_load_val = T_W'(BLANK_CYCLES - 1);
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Column index: advances at the end of each lit column, wraps after N-1,
  // and is parked at 0 whenever the scanner goes idle.
  always_comb begin
    x_next = x_reg;
    if (col_end) begin
      x_next = last_col ? '0 : x_reg + X_W'(1);
    end
    if (state_next == S_IDLE) begin
      x_next = '0;
    end
  end

  // Accept and swap are mutually exclusive: accept needs the buffer empty,
  // swap needs it full. A transfer landing on a frame end with an empty
  // buffer therefore waits in pending for the following frame.
  assign accept = cells_valid && cells_ready_reg;
  assign swap   = pending_full_reg && (frame_end || (state_reg == S_IDLE));

  always_comb begin
    pending_full_next = pending_full_reg;
    if (accept) begin
      pending_full_next = 1'b1;
    end else if (swap) begin
      pending_full_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      x_reg            <= '0;
      ena_reg          <= 1'b0;
      frame_done_reg   <= 1'b0;
      cells_out_reg    <= '0;
      pending_reg      <= '0;
      pending_full_reg <= 1'b0;
      cells_ready_reg  <= 1'b1;
    end else begin
      state_reg        <= state_next;
      x_reg            <= x_next;
      ena_reg          <= (state_next == S_SHOW);
      frame_done_reg   <= frame_end;
      pending_full_reg <= pending_full_next;
      cells_ready_reg  <= !pending_full_next;
      if (accept) begin
        pending_reg <= cells_in;
      end
      if (swap) begin
        cells_out_reg <= pending_reg;
      end
    end
  end

  assign ena         = ena_reg;
  assign x           = x_reg;
  assign cells_out   = cells_out_reg;
  assign frame_done  = frame_done_reg;
  assign cells_ready = cells_ready_reg;

endmodule

// File: tb/tb_led_frame_scanner.sv
// Directed bench for led_frame_scanner with N=5, DWELL_CYCLES=4, BLANK_CYCLES=2.
// Column period is 6 cycles, frame period 30 cycles. t counts clock edges since
// reset release; while scanning, after edge t: x=(t/6)%5, ena=(t%6)>=2,
// frame_done=(t%30==0, t>0), and cells_out may only change when t%30==0.
module tb_led_frame_scanner;

  localparam int N  = 5;
  localparam int NN = N * N;

  logic          clk;
  logic          rst;
  logic          run;
  logic [NN-1:0] cells_in;
  logic          cells_valid;
  logic          cells_ready;
  logic          ena;
  logic [3:0]    x;
  logic [NN-1:0] cells_out;
  logic          frame_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int t            = 0;

  led_frame_scanner #(
    .N            (N),
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .cells_in    (cells_in),
    .cells_valid (cells_valid),
    .cells_ready (cells_ready),
    .ena         (ena),
    .x           (x),
    .cells_out   (cells_out),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Advance one edge; outputs are read 1 time unit after the edge and inputs
  // changed there are seen by the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic align(input int m);
    for (int i = 0; i < 30 && (t % 30) != m; i++) tick();
  endtask

  task automatic test_reset();
    int exp_ena [7];
    exp_ena = '{0, 0, 1, 1, 1, 1, 0};
    rst = 1'b1; run = 1'b1; cells_valid = 1'b0; cells_in = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (ena !== 1'b0 || x !== 4'd0 || cells_out !== '0 || cells_ready !== 1'b1 ||
          frame_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_values cycle %0d: got ena=%b x=%0d cells_out=%h ready=%b fd=%b, expected 0 0 0 1 0",
                 k, ena, x, cells_out, cells_ready, frame_done);
      end
    end
    rst = 1'b0;
    t = -1;
    for (int k = 0; k < 7; k++) begin
      tick();
      tests_run++;
      if (ena !== 1'(exp_ena[k])) begin
        tests_failed++;
        $display("FAIL startup_ena edge %0d: got %b expected %0d", k, ena, exp_ena[k]);
      end
      tests_run++;
      if (x !== ((k == 6) ? 4'd1 : 4'd0)) begin
        tests_failed++;
        $display("FAIL startup_x edge %0d: got %0d expected %0d", k, x, (k == 6) ? 1 : 0);
      end
    end
    $display("[TB] reset and first column checked");
  endtask

  task automatic test_scan();
    logic [3:0] exp_x;
    logic       exp_e, exp_fd;
    for (int k = 0; k < 60; k++) begin
      tick();
      exp_x  = 4'((t / 6) % 5);
      exp_e  = ((t % 6) >= 2);
      exp_fd = ((t % 30) == 0);
      tests_run++;
      if (x !== exp_x || ena !== exp_e || frame_done !== exp_fd) begin
        tests_failed++;
        $display("FAIL scan t=%0d: got x=%0d ena=%b fd=%b expected x=%0d ena=%b fd=%b",
                 t, x, ena, frame_done, exp_x, exp_e, exp_fd);
      end
    end
    $display("[TB] free-running scan over two frames checked");
  endtask

  task automatic test_swap();
    align(10);
    cells_in = 25'h1F; cells_valid = 1'b1;
    tick();
    cells_valid = 1'b0; cells_in = '0;
    $display("[TB] load cells 0x%h mid-frame", 25'h1F);
    tests_run++;
    if (cells_ready !== 1'b0 || cells_out !== '0) begin
      tests_failed++;
      $display("FAIL swap_accept: got ready=%b cells_out=%h expected 0 0", cells_ready, cells_out);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if ((t % 30) == 0) break;
      tests_run++;
      if (cells_out !== '0 || cells_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL swap_hold t=%0d: got cells_out=%h ready=%b expected 0 0", t, cells_out, cells_ready);
      end
    end
    tests_run++;
    if (cells_out !== 25'h1F || cells_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL swap_frame_end: got cells_out=%h ready=%b expected 1f 1", cells_out, cells_ready);
    end
  endtask

  task automatic test_stall();
    align(5);
    cells_in = 25'h1234567; cells_valid = 1'b1;
    tick();
    $display("[TB] load cells 0x%h", 25'h1234567);
    tests_run++;
    if (cells_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_first_accept: got ready=%b expected 0", cells_ready);
    end
    cells_in = 25'h0AAAAAA;
    for (int i = 0; i < 30; i++) begin
      tick();
      if ((t % 30) == 0) break;
      tests_run++;
      if (cells_ready !== 1'b0 || cells_out !== 25'h1F) begin
        tests_failed++;
        $display("FAIL stall_hold t=%0d: got ready=%b cells_out=%h expected 0 1f", t, cells_ready, cells_out);
      end
    end
    tests_run++;
    if (cells_out !== 25'h1234567 || cells_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_swap: got cells_out=%h ready=%b expected 1234567 1", cells_out, cells_ready);
    end
    tick();
    cells_valid = 1'b0; cells_in = '0;
    $display("[TB] load cells 0x%h after stall", 25'h0AAAAAA);
    tests_run++;
    if (cells_ready !== 1'b0 || cells_out !== 25'h1234567) begin
      tests_failed++;
      $display("FAIL stall_second_accept: got ready=%b cells_out=%h expected 0 1234567", cells_ready, cells_out);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if ((t % 30) == 0) break;
      tests_run++;
      if (cells_out !== 25'h1234567) begin
        tests_failed++;
        $display("FAIL stall_second_hold t=%0d: got cells_out=%h expected 1234567", t, cells_out);
      end
    end
    tests_run++;
    if (cells_out !== 25'h0AAAAAA || cells_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_second_swap: got cells_out=%h ready=%b expected 0aaaaaa 1", cells_out, cells_ready);
    end
  endtask

  task automatic test_stop();
    logic       exp_e [6];
    logic [3:0] exp_x [6];
    exp_e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_x = '{4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};
    align(15);
    tests_run++;
    if (ena !== 1'b1 || x !== 4'd2) begin
      tests_failed++;
      $display("FAIL stop_start: got ena=%b x=%0d expected 1 2", ena, x);
    end
    run = 1'b0;
    $display("[TB] run dropped during column 2");
    for (int k = 0; k < 6; k++) begin
      tick();
      tests_run++;
      if (ena !== exp_e[k] || x !== exp_x[k] || frame_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL stop_step %0d: got ena=%b x=%0d fd=%b expected %b %0d 0",
                 k, ena, x, frame_done, exp_e[k], exp_x[k]);
      end
    end
    cells_in = 25'h1C0FFEE; cells_valid = 1'b1;
    tick();
    cells_valid = 1'b0; cells_in = '0;
    $display("[TB] load cells 0x%h while idle", 25'h1C0FFEE);
    tests_run++;
    if (cells_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_accept: got ready=%b expected 0", cells_ready);
    end
    tick();
    tests_run++;
    if (cells_out !== 25'h1C0FFEE || cells_ready !== 1'b1 || ena !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_swap: got cells_out=%h ready=%b ena=%b expected 1c0ffee 1 0",
               cells_out, cells_ready, ena);
    end
  endtask

  task automatic test_rst_mid();
    run = 1'b1;
    tick(); tick(); tick();
    tests_run++;
    if (ena !== 1'b1 || x !== 4'd0) begin
      tests_failed++;
      $display("FAIL restart_show: got ena=%b x=%0d expected 1 0", ena, x);
    end
    cells_in = 25'h0F0F0F; cells_valid = 1'b1;
    tick();
    cells_valid = 1'b0; cells_in = '0;
    $display("[TB] load cells 0x%h during column 0", 25'h0F0F0F);
    tests_run++;
    if (cells_ready !== 1'b0 || ena !== 1'b1 || cells_out !== 25'h1C0FFEE) begin
      tests_failed++;
      $display("FAIL rst_mid_pending: got ready=%b ena=%b cells_out=%h expected 0 1 1c0ffee",
               cells_ready, ena, cells_out);
    end
    rst = 1'b1;
    tick();
    $display("[TB] reset asserted mid-column");
    tests_run++;
    if (ena !== 1'b0 || x !== 4'd0 || cells_out !== '0 || cells_ready !== 1'b1 ||
        frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_values: got ena=%b x=%0d cells_out=%h ready=%b fd=%b expected 0 0 0 1 0",
               ena, x, cells_out, cells_ready, frame_done);
    end
    rst = 1'b0; run = 1'b0;
    tick(); tick(); tick();
    tests_run++;
    if (cells_out !== '0 || cells_ready !== 1'b1 || ena !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_discard: got cells_out=%h ready=%b ena=%b expected 0 1 0",
               cells_out, cells_ready, ena);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; cells_valid = 1'b0; cells_in = '0;
    test_reset();
    test_scan();
    test_swap();
    test_stall();
    test_stop();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
